// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the MULT/MULTU/DIV/DIVU opcodes (also decoded by the hazard unit),
// the FSM state encoding, and the iteration-counter width helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  // Counter must hold values 0..xlen.
  function automatic int unsigned cnt_width(input int unsigned xlen);
    return $clog2(xlen + 1);
  endfunction

endpackage

// File: rtl/twos_abs_neg.sv
// Conditional two's-complement negation, used as absolute value on operand
// entry (neg = signed op & sign bit) and as sign correction of results.
// Ports:
//   neg   - negate x when high
//   x     - input value
//   res_c - x or -x (combinational)
module twos_abs_neg #(
  parameter int unsigned XLEN = 32
) (
  input  logic            neg,
  input  logic [XLEN-1:0] x,
  output logic [XLEN-1:0] res_c
);

  assign res_c = neg ? (~x + XLEN'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the MIPS EX stage.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; each takes one
// RUN cycle per bit plus a FIX cycle for sign correction and commit.
// Ports:
//   clk, rst          - clock, async active-low reset
//   start, op, a, b   - launch request, opcode, operands (sampled in IDLE)
//   flush             - abort a running or requested operation
//   mthi, mtlo, wdata - direct HI/LO writes (IDLE only)
//   busy, done        - operation in progress / one-cycle result pulse
//   div_by_zero       - last completed divide had a zero divisor
//   hi, lo            - HI/LO result registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned W2 = 2 * XLEN;
  localparam int unsigned CW = cnt_width(XLEN);

  state_e          state_q, state_d;
  logic [W2-1:0]   acc_q, acc_d;      // mult: {partial, multiplier}; div: {rem, quo}
  logic [XLEN-1:0] dreg_q, dreg_d;    // multiplicand or divisor magnitude
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            div_q, div_d;
  logic            qneg_q, qneg_d;    // product / quotient sign
  logic            rneg_q, rneg_d;    // remainder sign
  logic            zero_q, zero_d;    // divide with b == 0
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            dbz_q, dbz_d, done_q, done_d, busy_q, busy_d;

  // Operand entry: magnitudes of signed operands
  op_e             op_in;
  logic            is_signed_c, a_neg_c, b_neg_c, launch_c;
  logic [XLEN-1:0] abs_a_c, abs_b_c;

  assign op_in       = op_e'(op);
  assign is_signed_c = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign a_neg_c     = is_signed_c & a[XLEN-1];
  assign b_neg_c     = is_signed_c & b[XLEN-1];
  assign launch_c    = (state_q == ST_IDLE) & start & ~flush;

  twos_abs_neg #(.XLEN(XLEN)) u_abs_a (.neg(a_neg_c), .x(a), .res_c(abs_a_c));
  twos_abs_neg #(.XLEN(XLEN)) u_abs_b (.neg(b_neg_c), .x(b), .res_c(abs_b_c));

  // Shift-add step: add multiplicand to upper half when LSB set, then shift right
  logic [XLEN:0]   sum_c;
  logic [W2-1:0]   mul_next_c;
  assign sum_c      = {1'b0, acc_q[W2-1:XLEN]} + {1'b0, dreg_q};
  assign mul_next_c = acc_q[0] ? {sum_c, acc_q[XLEN-1:1]} : {1'b0, acc_q[W2-1:1]};

  // Restoring step: shifted remainder needs XLEN+1 bits for the compare
  logic [XLEN:0]   rem_c;
  logic [XLEN-1:0] diff_c;
  logic            ge_c;
  logic [W2-1:0]   div_next_c;
  assign rem_c      = acc_q[W2-1:XLEN-1];
  assign ge_c       = rem_c >= {1'b0, dreg_q};
  assign diff_c     = rem_c[XLEN-1:0] - dreg_q;
  assign div_next_c = ge_c ? {diff_c, acc_q[XLEN-2:0], 1'b1} : {acc_q[W2-2:0], 1'b0};

  // Sign correction of results
  logic [W2-1:0]   prod_fix_c;
  logic [XLEN-1:0] quo_fix_c, rem_fix_c;

  twos_abs_neg #(.XLEN(W2))   u_fix_prod (.neg(qneg_q), .x(acc_q), .res_c(prod_fix_c));
  twos_abs_neg #(.XLEN(XLEN)) u_fix_quo  (.neg(qneg_q), .x(acc_q[XLEN-1:0]), .res_c(quo_fix_c));
  twos_abs_neg #(.XLEN(XLEN)) u_fix_rem  (.neg(rneg_q), .x(acc_q[W2-1:XLEN]), .res_c(rem_fix_c));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (launch_c) state_d = ST_RUN;
      ST_RUN: begin
        if (flush)                          state_d = ST_IDLE;
        else if (cnt_q == CW'(XLEN - 1))    state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    acc_d  = acc_q;
    dreg_d = dreg_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    zero_d = zero_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    dbz_d  = dbz_q;
    done_d = 1'b0;
    busy_d = (state_d != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (launch_c) begin
          div_d  = op[1];
          acc_d  = op[1] ? {XLEN'(0), abs_a_c} : {XLEN'(0), abs_b_c};
          dreg_d = op[1] ? abs_b_c : abs_a_c;
          cnt_d  = '0;
          qneg_d = a_neg_c ^ b_neg_c;
          rneg_d = a_neg_c;
          zero_d = op[1] & (b == '0);
          dbz_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (!flush) begin
          acc_d = div_q ? div_next_c : mul_next_c;
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FIX: begin
        done_d = 1'b1;
        dbz_d  = zero_q;
        if (div_q) begin
          hi_d = rem_fix_c;                      // equals a when b == 0
          lo_d = zero_q ? '1 : quo_fix_c;
        end else begin
          {hi_d, lo_d} = prod_fix_c;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      dreg_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      zero_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      dbz_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      dreg_q <= dreg_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      zero_q <= zero_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      dbz_q  <= dbz_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (XLEN=32) with hand-computed results.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, flush, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Launch one op and wait (bounded) for done; leaves the bench in the done cycle.
  // lat = cycle index of done counted from the start cycle, 0 on timeout.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcnt, output logic dbz1);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    dbz1 = div_by_zero;
    lat  = 0;
    bcnt = 0;
    for (int i = 1; i <= 60; i++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  int   lat, bcnt, nd;
  logic dbz1;

  initial begin
    rst = 1'b0; start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    #12;
    check("rst_hilo", {hi, lo}, 64'h0);
    check("rst_flags", {61'h0, busy, done, div_by_zero}, 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // MULTU max x max, with latency and busy length
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt, dbz1);
    check("multu_lat", 64'(lat), 64'd34);
    check("multu_busy", 64'(bcnt), 64'd33);
    check("multu_res", {hi, lo}, 64'hFFFFFFFE_00000001);

    // MULT -3 x 5
    run_op(2'b00, 32'hFFFFFFFD, 32'd5, lat, bcnt, dbz1);
    check("mult_lat", 64'(lat), 64'd34);
    check("mult_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);

    // DIV -7 / 2
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, lat, bcnt, dbz1);
    check("div_lat", 64'(lat), 64'd34);
    check("div_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    // DIVU 7 / 0
    run_op(2'b11, 32'd7, 32'd0, lat, bcnt, dbz1);
    check("dbz_lat", 64'(lat), 64'd34);
    check("dbz_res", {hi, lo}, 64'h00000007_FFFFFFFF);
    check("dbz_flag", 64'(div_by_zero), 64'd1);

    // MULTU 2 x 3 clears div_by_zero on launch
    run_op(2'b01, 32'd2, 32'd3, lat, bcnt, dbz1);
    check("dbz_clr", 64'(dbz1), 64'd0);
    check("multu_small", {hi, lo}, 64'h00000000_00000006);

    // DIV most-negative / -1 wraps
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, bcnt, dbz1);
    check("div_ovf", {hi, lo}, 64'h00000000_80000000);
    check("div_ovf_dbz", 64'(div_by_zero), 64'd0);

    // DIVU 100 / 7 with flush in the FIX cycle (ignored)
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    check("fix_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fix_flush_done", 64'(done), 64'd1);
    check("fix_flush_res", {hi, lo}, 64'h00000002_0000000E);

    // MULTU 3 x 4 flushed on RUN cycle 10; start and mtlo while busy ignored
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    check("fl_busy1", 64'(busy), 64'd1);
    repeat (2) @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3; mtlo = 1'b1; wdata = 32'hAA;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    check("busy_mtlo", 64'(lo), 64'h0000000E);
    check("busy_still", 64'(busy), 64'd1);
    repeat (6) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_busy0", 64'(busy), 64'd0);
    check("fl_done0", 64'(done), 64'd0);
    count_done(40, nd);
    check("fl_nodone", 64'(nd), 64'd0);
    check("fl_keep", {hi, lo}, 64'h00000002_0000000E);

    // start and flush together in IDLE: nothing launches
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("sf_busy", 64'(busy), 64'd0);
    count_done(40, nd);
    check("sf_nodone", 64'(nd), 64'd0);
    check("sf_keep", {hi, lo}, 64'h00000002_0000000E);

    // MTHI / MTLO in IDLE
    @(negedge clk);
    mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi", 64'(hi), 64'h1234);
    mtlo = 1'b1; wdata = 32'h5678;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo", {hi, lo}, 64'h00001234_00005678);

    // Reset asserted mid-RUN
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_hilo", {hi, lo}, 64'h0);
    check("mid_rst_flags", {61'h0, busy, done, div_by_zero}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    count_done(40, nd);
    check("mid_rst_nodone", 64'(nd), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
